// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the pipelined CORDIC rotator.
//
// Contents:
//   - quadrant codes for the top two phase bits
//   - atan32()     : atan(2^-i) scaled so that 2^32 is one full turn
//   - atan_const() : the same angle rounded to a zw-bit phase word
//   - cordic_latency() : accept-to-strobe_out latency in clocks
//
// Build option: CORDIC_GAIN_COMP_EN adds the 1/K output stage (one extra clock).
package cordic_pkg;

    // Top two bits of the phase word.
    localparam logic [1:0] QUAD_0_90    = 2'b00;
    localparam logic [1:0] QUAD_90_180  = 2'b01;
    localparam logic [1:0] QUAD_180_270 = 2'b10;
    localparam logic [1:0] QUAD_270_360 = 2'b11;

    // atan(2^-i) / (2*pi) * 2^32. Past i = 12 atan(x) equals x to far better
    // than 32-bit precision, so the angle is just 2^32 / (2*pi) / 2^i.
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:       atan32 = 32'h2000_0000;
            1:       atan32 = 32'h12E4_051E;
            2:       atan32 = 32'h09FB_385B;
            3:       atan32 = 32'h0511_11D4;
            4:       atan32 = 32'h028B_0D43;
            5:       atan32 = 32'h0145_D7E1;
            6:       atan32 = 32'h00A2_F61E;
            7:       atan32 = 32'h0051_7C55;
            8:       atan32 = 32'h0028_BE53;
            9:       atan32 = 32'h0014_5F2F;
            10:      atan32 = 32'h000A_2F98;
            11:      atan32 = 32'h0005_17CC;
            12:      atan32 = 32'h0002_8BE6;
            default: atan32 = 32'd683565276 >> i;
        endcase
    endfunction

    // Round-to-nearest reduction of the 32-bit angle down to zw bits.
    function automatic logic [31:0] atan_const(input int i, input int zw);
        logic [32:0] r;
        if (zw >= 32) return atan32(i);
        r = {1'b0, atan32(i)} + (33'd1 << (31 - zw));
        return 32'(r >> (32 - zw));
    endfunction

    // One pre-rotation register, one register per micro-rotation stage,
    // plus the optional gain-compensation register.
    function automatic int cordic_latency(input int stages);
`ifdef CORDIC_GAIN_COMP_EN
        return stages + 2;
`else
        return stages + 1;
`endif
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation stage (registered).
//
// Rotates (x, y) by +/- atan(2^-SHIFT) towards driving z to zero.
// Parameters: WIDTH  - datapath width of x/y (already includes guard bits)
//             ZWIDTH - phase width, wraps modulo 2^ZWIDTH
//             SHIFT  - stage index i (shift amount)
//             ATAN   - phase constant for this stage
// Ports:      clk, reset (sync, active-high)
//             valid_i/x_i/y_i/z_i - previous stage
//             valid_o/x_o/y_o/z_o - registered result
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int                WIDTH  = 18,
    parameter int                ZWIDTH = 16,
    parameter int                SHIFT  = 0,
    parameter logic [ZWIDTH-1:0] ATAN   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic signed [WIDTH-1:0]  x_i,
    input  logic signed [WIDTH-1:0]  y_i,
    input  logic        [ZWIDTH-1:0] z_i,
    output logic                     valid_o,
    output logic signed [WIDTH-1:0]  x_o,
    output logic signed [WIDTH-1:0]  y_o,
    output logic        [ZWIDTH-1:0] z_o
);

    logic signed [WIDTH-1:0]  x_sh, y_sh;
    logic signed [WIDTH-1:0]  x_d, y_d, x_q, y_q;
    logic        [ZWIDTH-1:0] z_d, z_q;
    logic                     valid_q;

    assign x_sh = x_i >>> SHIFT;
    assign y_sh = y_i >>> SHIFT;

    // Negative residual angle (sign bit set) means rotate clockwise.
    always_comb begin
        if (z_i[ZWIDTH-1]) begin
            x_d = x_i + y_sh;
            y_d = y_i - x_sh;
            z_d = z_i + ATAN;
        end else begin
            x_d = x_i - y_sh;
            y_d = y_i + x_sh;
            z_d = z_i - ATAN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_i;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/cordic_rotator.sv
// Pipelined CORDIC rotator (digital mixer after the DDS phase accumulator).
//
// Rotates (xi, yi) by the angle zi (2^ZWIDTH = one turn). A quadrant
// pre-rotation register is followed by STAGES micro-rotation stages.
// Output carries the CORDIC gain K ~ 1.64676 unless CORDIC_GAIN_COMP_EN is
// defined, which adds a 1/K shift-add stage and one clock of latency.
//
// Ports: clk, reset (sync, active-high), enable, strobe_in (accept when both
//        high), xi/yi (WIDTH signed), zi (ZWIDTH phase),
//        xo/yo (WIDTH+2 signed), strobe_out (output valid).
// Free-running pipeline: no backpressure, one sample per clock, latency
// cordic_latency(STAGES). STAGES must be in 1..ZWIDTH-4.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ZWIDTH = 16,
    parameter int STAGES = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    strobe_in,
    input  logic signed [WIDTH-1:0] xi,
    input  logic signed [WIDTH-1:0] yi,
    input  logic       [ZWIDTH-1:0] zi,
    output logic signed [WIDTH+1:0] xo,
    output logic signed [WIDTH+1:0] yo,
    output logic                    strobe_out
);

    localparam int DW = WIDTH + 2;
    localparam logic [ZWIDTH-1:0] QUARTER = {2'b01, {(ZWIDTH-2){1'b0}}};

    // Two guard bits: one absorbs negating -2^(WIDTH-1), one absorbs gain K.
    logic signed [DW-1:0]     x_ext, y_ext, x0_d, y0_d, x0_q, y0_q;
    logic        [ZWIDTH-1:0] z0_d, z0_q;
    logic                     v0_q;

    assign x_ext = {{2{xi[WIDTH-1]}}, xi};
    assign y_ext = {{2{yi[WIDTH-1]}}, yi};

    // Fold the angle into [-90, +90) degrees so the micro-rotations converge.
    always_comb begin
        x0_d = x_ext;
        y0_d = y_ext;
        z0_d = zi;
        case (zi[ZWIDTH-1 -: 2])
            QUAD_90_180: begin
                x0_d = -y_ext;
                y0_d = x_ext;
                z0_d = zi - QUARTER;
            end
            QUAD_180_270: begin
                x0_d = y_ext;
                y0_d = -x_ext;
                z0_d = zi + QUARTER;
            end
            default: ;
        endcase
    end

    // Data registers load every clock; only the valid bit honours the accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q <= '0;
            y0_q <= '0;
            z0_q <= '0;
            v0_q <= 1'b0;
        end else begin
            x0_q <= x0_d;
            y0_q <= y0_d;
            z0_q <= z0_d;
            v0_q <= enable && strobe_in;
        end
    end

    logic signed [DW-1:0]     xs [STAGES];
    logic signed [DW-1:0]     ys [STAGES];
    logic        [ZWIDTH-1:0] zs [STAGES];
    logic                     vs [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic signed [DW-1:0]     x_in, y_in;
        logic        [ZWIDTH-1:0] z_in;
        logic                     v_in;

        if (i == 0) begin : g_first
            assign x_in = x0_q;
            assign y_in = y0_q;
            assign z_in = z0_q;
            assign v_in = v0_q;
        end else begin : g_next
            assign x_in = xs[i-1];
            assign y_in = ys[i-1];
            assign z_in = zs[i-1];
            assign v_in = vs[i-1];
        end

        cordic_stage #(
            .WIDTH  (DW),
            .ZWIDTH (ZWIDTH),
            .SHIFT  (i),
            .ATAN   (ZWIDTH'(atan_const(i, ZWIDTH)))
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .valid_i (v_in),
            .x_i     (x_in),
            .y_i     (y_in),
            .z_i     (z_in),
            .valid_o (vs[i]),
            .x_o     (xs[i]),
            .y_o     (ys[i]),
            .z_o     (zs[i])
        );
    end

    // The final residual angle zs[STAGES-1] is intentionally left unused.
`ifdef CORDIC_GAIN_COMP_EN
    // v * (1/2 + 1/8 - 1/64 - 1/512) = 0.607421875 * v, close to 1/K.
    function automatic logic signed [DW-1:0] inv_gain(input logic signed [DW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction

    logic signed [DW-1:0] xo_q, yo_q;
    logic                 so_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xo_q <= '0;
            yo_q <= '0;
            so_q <= 1'b0;
        end else begin
            xo_q <= inv_gain(xs[STAGES-1]);
            yo_q <= inv_gain(ys[STAGES-1]);
            so_q <= vs[STAGES-1];
        end
    end

    assign xo         = xo_q;
    assign yo         = yo_q;
    assign strobe_out = so_q;
`else
    assign xo         = xs[STAGES-1];
    assign yo         = ys[STAGES-1];
    assign strobe_out = vs[STAGES-1];
`endif

endmodule

// File: tb/tb_cordic_rotator.sv
module tb_cordic_rotator;

  localparam int W  = 16;
  localparam int ZW = 16;
  localparam int ST = 12;
  localparam int OW = W + 2;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT = ST + 2;
  localparam real GC  = 0.607421875;
`else
  localparam int  LAT = ST + 1;
  localparam real GC  = 1.0;
`endif
  localparam real PI = 3.14159265358979;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic                 strobe_in;
  logic signed [W-1:0]  xi;
  logic signed [W-1:0]  yi;
  logic [ZW-1:0]        zi;
  logic signed [OW-1:0] xo;
  logic signed [OW-1:0] yo;
  logic                 strobe_out;

  cordic_rotator #(.WIDTH(W), .ZWIDTH(ZW), .STAGES(ST)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .strobe_in  (strobe_in),
    .xi         (xi),
    .yi         (yi),
    .zi         (zi),
    .xo         (xo),
    .yo         (yo),
    .strobe_out (strobe_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_cmp  = 0;
  int  n_fail = 0;
  int  atan_tb[ST];
  real kgain;

  // ---------------- reference model ----------------
  // Rotation by z expressed as: fold to +/-90 degrees, then ST signed
  // shift-add micro-rotations on plain integers; angles from $atan.
  function automatic logic [2*OW-1:0] model(input logic signed [W-1:0] x_in,
                                            input logic signed [W-1:0] y_in,
                                            input logic [ZW-1:0] z_in);
    int x, y, t;
    logic [ZW-1:0] z;
    logic [OW-1:0] rx, ry;
    x = x_in;
    y = y_in;
    z = z_in;
    if (z_in[ZW-1:ZW-2] == 2'b01) begin
      t = x; x = -y; y = t; z = z_in - 16'h4000;
    end else if (z_in[ZW-1:ZW-2] == 2'b10) begin
      t = x; x = y; y = -t; z = z_in + 16'h4000;
    end
    for (int i = 0; i < ST; i++) begin
      if (z[ZW-1] == 1'b0) begin
        t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - atan_tb[i][ZW-1:0];
      end else begin
        t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + atan_tb[i][ZW-1:0];
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9);
`endif
    rx = x[OW-1:0];
    ry = y[OW-1:0];
    return {rx, ry};
  endfunction

  // Ideal (real-valued) rotation including the uncompensated gain.
  function automatic real ideal(input int x, input int y, input logic [ZW-1:0] z, input bit want_y);
    real th;
    th = 2.0 * PI * real'(z) / 65536.0;
    if (want_y) return kgain * GC * (real'(x) * $sin(th) + real'(y) * $cos(th));
    return kgain * GC * (real'(x) * $cos(th) - real'(y) * $sin(th));
  endfunction

  // Allowed distance from the ideal: angular resolution of the last stage
  // applied to the output magnitude, plus a few LSBs of truncation.
  function automatic real tol_for(input int x, input int y);
    real mag;
    mag = kgain * GC * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    return 3.0 + mag * 2.0 * PI * real'(atan_tb[ST-1]) / 65536.0;
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // ---------------- scoreboard ----------------
  // Entry = {valid, must_be_zero, x[OW], y[OW]}; front = expected output now.
  logic [2*OW+1:0] exp_q[$];

  always @(posedge clk) begin
    logic [2*OW+1:0] r;
    if (enable && strobe_in) r = {2'b10, model(xi, yi, zi)};
    else                     r = '0;
    exp_q.push_back(r);
    if (exp_q.size() > LAT) void'(exp_q.pop_front());
    if (reset) foreach (exp_q[k]) exp_q[k] = {2'b01, {(2*OW){1'b0}}};
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic st, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [ZW-1:0] z);
    enable    = en;
    strobe_in = st;
    xi        = x;
    yi        = y;
    zi        = z;
    @(posedge clk);
    #1;
  endtask

  // Sends one sample, then idles; reports the edge (accept edge = 1) at which
  // strobe_out first rose, or -1 if it never did within the bound.
  task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic [ZW-1:0] z,
                          output int hit, output logic signed [OW-1:0] cx, output logic signed [OW-1:0] cy);
    hit = -1;
    cx  = '0;
    cy  = '0;
    step(1'b1, 1'b1, x, y, z);
    if (strobe_out === 1'b1) begin hit = 1; cx = xo; cy = yo; end
    for (int n = 2; n <= LAT + 4; n++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      if (strobe_out === 1'b1 && hit < 0) begin hit = n; cx = xo; cy = yo; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      n_cmp++;
      if (strobe_out !== 1'b0 || xo !== '0 || yo !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got strobe=%b xo=%0d yo=%0d need 0/0/0", c, strobe_out, xo, yo);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    int hit;
    logic signed [OW-1:0] cx, cy;
    real ex, ey, tol;
    send_one(16'd10000, 16'd0, 16'h0000, hit, cx, cy);
    n_cmp++;
    if (hit != LAT) begin
      n_fail++;
      $display("FAIL latency got=%0d need=%0d", hit, LAT);
    end
    ex  = ideal(10000, 0, 16'h0000, 1'b0);
    ey  = ideal(10000, 0, 16'h0000, 1'b1);
    tol = tol_for(10000, 0);
    n_cmp++;
    if (rabs(real'(cx) - ex) > tol || rabs(real'(cy) - ey) > tol) begin
      n_fail++;
      $display("FAIL latency_value got=(%0d,%0d) need=(%0.1f,%0.1f)+-%0.1f", cx, cy, ex, ey, tol);
    end
    n_cmp++;
    if ({cx, cy} !== model(16'sd10000, 16'sd0, 16'h0000)) begin
      n_fail++;
      $display("FAIL latency_exact got=(%0d,%0d) need=%h", cx, cy, model(16'sd10000, 16'sd0, 16'h0000));
    end
  endtask

  task automatic test_quadrants();
    logic [ZW-1:0] zs[3] = '{16'h4000, 16'h8000, 16'hC000};
    int hit;
    logic signed [OW-1:0] cx, cy;
    real ex, ey, tol;
    foreach (zs[q]) begin
      send_one(16'd10000, 16'd0, zs[q], hit, cx, cy);
      n_cmp++;
      if (hit != LAT) begin
        n_fail++;
        $display("FAIL quad_latency z=%h got=%0d need=%0d", zs[q], hit, LAT);
      end
      ex  = ideal(10000, 0, zs[q], 1'b0);
      ey  = ideal(10000, 0, zs[q], 1'b1);
      tol = tol_for(10000, 0);
      n_cmp++;
      if (rabs(real'(cx) - ex) > tol || rabs(real'(cy) - ey) > tol) begin
        n_fail++;
        $display("FAIL quad_value z=%h got=(%0d,%0d) need=(%0.1f,%0.1f)+-%0.1f", zs[q], cx, cy, ex, ey, tol);
      end
      n_cmp++;
      if ({cx, cy} !== model(16'sd10000, 16'sd0, zs[q])) begin
        n_fail++;
        $display("FAIL quad_exact z=%h got=(%0d,%0d)", zs[q], cx, cy);
      end
    end
  endtask

  task automatic test_extremes();
    logic [ZW-1:0] zs[4] = '{16'h2000, 16'h6000, 16'hA000, 16'hE000};
    int hit, ax, ay;
    logic signed [OW-1:0] cx, cy;
    foreach (zs[q]) begin
      send_one(16'h8000, 16'h8000, zs[q], hit, cx, cy);
      ax = cx;
      ay = cy;
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      n_cmp++;
      if (hit != LAT || ax > 76400 || ay > 76400) begin
        n_fail++;
        $display("FAIL extreme_bound z=%h lat=%0d got=(%0d,%0d) need |v|<=76400", zs[q], hit, cx, cy);
      end
      n_cmp++;
      if ({cx, cy} !== model(-16'sd32768, -16'sd32768, zs[q])) begin
        n_fail++;
        $display("FAIL extreme_exact z=%h got=(%0d,%0d) need=%h", zs[q], cx, cy,
                 model(-16'sd32768, -16'sd32768, zs[q]));
      end
    end
  endtask

  task automatic test_throughput();
    logic [2*OW+1:0] e;
    for (int c = 0; c < 64 + LAT + 2; c++) begin
      if (c < 64) step(((c / 4) % 2) == 0, 1'b1, 16'($urandom), 16'($urandom), 16'(c * 256));
      else        step(1'b0, 1'b0, '0, '0, '0);
      e = exp_q[0];
      n_cmp++;
      if (strobe_out !== e[2*OW+1]) begin
        n_fail++;
        $display("FAIL thr_strobe cyc=%0d got=%b need=%b", c, strobe_out, e[2*OW+1]);
      end
      if (e[2*OW+1] | e[2*OW]) begin
        n_cmp++;
        if ({xo, yo} !== e[2*OW-1:0]) begin
          n_fail++;
          $display("FAIL thr_data cyc=%0d got=%h need=%h", c, {xo, yo}, e[2*OW-1:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2*OW+1:0] e;
    logic [W-1:0] rx, ry;
    for (int c = 0; c < 300 + LAT + 2; c++) begin
      rx = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      ry = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      if (c < 300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rx, ry, 16'($urandom));
      else         step(1'b0, 1'b0, '0, '0, '0);
      e = exp_q[0];
      n_cmp++;
      if (strobe_out !== e[2*OW+1]) begin
        n_fail++;
        $display("FAIL rnd_strobe cyc=%0d got=%b need=%b", c, strobe_out, e[2*OW+1]);
      end
      if (e[2*OW+1] | e[2*OW]) begin
        n_cmp++;
        if ({xo, yo} !== e[2*OW-1:0]) begin
          n_fail++;
          $display("FAIL rnd_data cyc=%0d got=%h need=%h", c, {xo, yo}, e[2*OW-1:0]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [2*OW+1:0] e;
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    reset = 1'b1;
    step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    reset = 1'b0;
    n_cmp++;
    if (strobe_out !== 1'b0 || xo !== '0 || yo !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear got strobe=%b xo=%0d yo=%0d need 0/0/0", strobe_out, xo, yo);
    end
    for (int c = 0; c < LAT + 4; c++) begin
      step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
      e = exp_q[0];
      n_cmp++;
      if (strobe_out !== e[2*OW+1]) begin
        n_fail++;
        $display("FAIL midreset_stale cyc=%0d got=%b need=%b", c, strobe_out, e[2*OW+1]);
      end
      if (e[2*OW]) begin
        n_cmp++;
        if (xo !== '0 || yo !== '0) begin
          n_fail++;
          $display("FAIL midreset_zero cyc=%0d got xo=%0d yo=%0d need 0/0", c, xo, yo);
        end
      end
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    strobe_in = 1'b0;
    xi        = '0;
    yi        = '0;
    zi        = '0;
    kgain     = 1.0;
    for (int i = 0; i < ST; i++) begin
      atan_tb[i] = $rtoi($atan(2.0 ** (-i)) / (2.0 * PI) * 65536.0 + 0.5);
      kgain      = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    test_reset();
    test_latency();
    test_quadrants();
    test_extremes();
    test_throughput();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
